// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter: load/store unit with one outstanding transaction on a request/response data bus.
// It rejects illegal or misaligned accesses locally and issues word-aligned bus transactions with byte enables.
module lsu_bus_adapter #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_wen,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wmask,
   input  logic                  mem_resp_valid,
   input  logic [31:0]           mem_rdata
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  wen_q, wen_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            off_q, off_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wmask_q, wmask_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  legal, misaligned, timed_out;
   logic [CW-1:0]         cnt_inc;
   logic [31:0]           w, ld;
   always_comb begin
      legal = req_wen ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                      : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
      // the response wins when it lands in the same cycle the budget runs out
      timed_out = int'(cnt_q) + 1 >= TIMEOUT;
      w = mem_rdata >> {off_q, 3'b000};
      ld = f3_q == 3'b000 ? {{24{w[7]}}, w[7:0]} :
           f3_q == 3'b100 ? {24'b0, w[7:0]} :
           f3_q == 3'b001 ? {{16{w[15]}}, w[15:0]} :
           f3_q == 3'b101 ? {16'b0, w[15:0]} : w;
      state_d = state_q;
      cnt_d   = '0;
      wen_d   = wen_q;
      f3_d    = f3_q;
      off_d   = off_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = '0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            wen_d   = req_wen;
            f3_d    = req_funct3;
            off_d   = req_addr[1:0];
            addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_d = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                      req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
            wmask_d = !req_wen ? 4'b0000 :
                      req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                      req_funct3[1:0] == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
            err_d   = !legal || misaligned;
            state_d = err_d ? RESP : REQ;
         end
         REQ: begin
            cnt_d   = cnt_inc;
            state_d = mem_req_ready ? WAIT : REQ;
         end
         WAIT: begin
            cnt_d = cnt_inc;
            if (mem_resp_valid) begin
               state_d = RESP;
               rdata_d = wen_q ? 32'h0 : ld;
            end else if (timed_out) begin
               state_d = RESP;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   // ready is qualified by rst so the core sees no acceptance while reset is held
   assign req_ready     = rst && state_q == IDLE;
   assign resp_valid    = state_q == RESP;
   assign resp_rdata    = rdata_q;
   assign resp_err      = err_q;
   assign mem_req_valid = state_q == REQ;
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q && state_q == REQ;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb_lsu_bus_adapter: scenario tasks checking the LSU against a byte-addressed reference memory model.
module tb_lsu_bus_adapter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_wen = 1'b0, req_ready;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req_valid, mem_wen;
   logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_wmask;
   int          checks = 0, failures = 0;
   logic [31:0] bmem [0:255];
   logic [7:0]  rmem [0:1023];

   lsu_bus_adapter #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input logic [31:0] a, input logic [31:0] v);
      bmem[a[9:2]] = v;
      for (int j = 0; j < 4; j++) rmem[{a[9:2], 2'b00} + j] = v[8*j +: 8];
   endtask

   task automatic run_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int rdly, input int wdly, input string nm);
      int          sz;
      logic        err;
      logic [31:0] ea, ew, er, word;
      logic [3:0]  em;
      sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err = f3 == 3'd3 || f3 >= 3'd6 || (wen && f3 >= 3'd4) || (addr % sz) != 0;
      ea  = addr & ~32'h3;
      em  = wen ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'h0;
      ew  = sz == 1 ? wd[7:0] * 32'h0101_0101 : sz == 2 ? wd[15:0] * 32'h0001_0001 : wd;
      er  = 32'h0;
      if (!wen && !err) begin
         for (int j = 0; j < sz; j++) er = er | (32'(rmem[addr + j]) << (8 * j));
         if (!f3[2] && sz < 4 && er[8*sz-1]) er = er | (32'hFFFF_FFFF << (8 * sz));
      end
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL %s idle_ready: got %b exp 1", nm, req_ready); end
      req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      step();
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
      if (err) begin
         checks++;
         if ({resp_valid, resp_err, resp_rdata, mem_req_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL %s err_resp: valid=%b err=%b rdata=%h mreq=%b exp 1 1 0 0", nm, resp_valid, resp_err, resp_rdata, mem_req_valid);
         end
      end else begin
         for (int i = 0; i <= rdly; i++) begin
            checks++;
            if ({mem_req_valid, req_ready, resp_valid, mem_wen, mem_addr, mem_wmask} !== {1'b1, 1'b0, 1'b0, wen, ea, em} ||
                (wen && mem_wdata !== ew)) begin
               failures++;
               $display("FAIL %s req_phase%0d: mreq=%b rdy=%b resp=%b wen=%b addr=%h mask=%b wdata=%h exp 1 0 0 %b %h %b %h",
                        nm, i, mem_req_valid, req_ready, resp_valid, mem_wen, mem_addr, mem_wmask, mem_wdata, wen, ea, em, ew);
            end
            if (i == rdly) begin
               mem_req_ready = 1'b1;
               word = bmem[mem_addr[9:2]];
               for (int j = 0; j < 4; j++) if (mem_wen && mem_wmask[j]) bmem[mem_addr[9:2]][8*j +: 8] = mem_wdata[8*j +: 8];
            end
            step();
            mem_req_ready = 1'b0;
         end
         for (int i = 0; i < wdly; i++) begin
            checks++;
            if ({mem_req_valid, resp_valid, req_ready} !== 3'b000) begin
               failures++; $display("FAIL %s wait%0d: mreq=%b resp=%b rdy=%b exp 0 0 0", nm, i, mem_req_valid, resp_valid, req_ready);
            end
            step();
         end
         checks++;
         if ({mem_req_valid, resp_valid} !== 2'b00) begin
            failures++; $display("FAIL %s wait_last: mreq=%b resp=%b exp 0 0", nm, mem_req_valid, resp_valid);
         end
         mem_resp_valid = 1'b1; mem_rdata = wen ? $urandom : word;
         step();
         mem_resp_valid = 1'b0; mem_rdata = $urandom;
         checks++;
         if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, er}) begin
            failures++; $display("FAIL %s resp: valid=%b err=%b rdata=%h exp 1 0 %h", nm, resp_valid, resp_err, resp_rdata, er);
         end
         if (wen) for (int j = 0; j < sz; j++) rmem[addr + j] = wd[8*j +: 8];
      end
      step();
      checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         failures++; $display("FAIL %s after_resp: resp=%b rdy=%b exp 0 1", nm, resp_valid, req_ready);
      end
   endtask

   task automatic test_reset;
      step(); step();
      checks++;
      if ({req_ready, resp_valid, resp_err, resp_rdata, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
         failures++; $display("FAIL reset_hold: rdy=%b resp=%b mreq=%b addr=%h exp all 0", req_ready, resp_valid, mem_req_valid, mem_addr);
      end
      #2 rst = 1'b1;
      step();
      checks++;
      if ({req_ready, resp_valid, mem_req_valid} !== 3'b100) begin
         failures++; $display("FAIL reset_release: rdy=%b resp=%b mreq=%b exp 1 0 0", req_ready, resp_valid, mem_req_valid);
      end
   endtask

   task automatic test_load_ext;
      set_word(32'h100, 32'h80FF_1234);
      run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, "lb_103");
      run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, "lbu_103");
      run_op(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, "lh_102");
      run_op(1'b0, 3'b101, 32'h100, 32'h0, 0, 0, "lhu_100");
   endtask

   task automatic test_store_stall;
      run_op(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 2, 0, "sh_202_stall");
      run_op(1'b1, 3'b000, 32'h205, 32'h1234_5677, 1, 1, "sb_205");
      run_op(1'b0, 3'b010, 32'h204, 32'h0, 0, 0, "lw_204");
   endtask

   task automatic test_errors;
      run_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, "lw_mis");
      run_op(1'b0, 3'b001, 32'h103, 32'h0, 0, 0, "lh_mis");
      run_op(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, "ld_f3_011");
      run_op(1'b1, 3'b100, 32'h100, 32'h0, 0, 0, "st_f3_100");
   endtask

   task automatic test_timeout;
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL to_idle: rdy=%b exp 1", req_ready); end
      req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
      step();
      req_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         checks++;
         if ({resp_valid, mem_req_valid} !== 2'b00) begin
            failures++; $display("FAIL to_wait_c%0d: resp=%b mreq=%b exp 0 0", c, resp_valid, mem_req_valid);
         end
         step();
      end
      checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
         failures++; $display("FAIL to_resp: valid=%b err=%b rdata=%h exp 1 1 0", resp_valid, resp_err, resp_rdata);
      end
      step();
      run_op(1'b0, 3'b010, 32'h44, 32'h0, 0, 2, "to_edge_resp");
      run_op(1'b0, 3'b000, 32'h47, 32'h0, 2, 0, "to_edge_stall");
   endtask

   task automatic test_async_reset;
      req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h48; req_wdata = 32'hCAFE_F00D;
      step();
      req_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({req_ready, resp_valid, resp_err, resp_rdata, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
         failures++; $display("FAIL arst_outputs: rdy=%b addr=%h wdata=%h mask=%b exp all 0", req_ready, mem_addr, mem_wdata, mem_wmask);
      end
      #2 rst = 1'b1;
      step();
      checks++;
      if ({req_ready, resp_valid} !== 2'b10) begin
         failures++; $display("FAIL arst_release: rdy=%b resp=%b exp 1 0", req_ready, resp_valid);
      end
      mem_resp_valid = 1'b1;
      step();
      mem_resp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({req_ready, resp_valid, mem_req_valid} !== 3'b100) begin
            failures++; $display("FAIL arst_ignore%0d: rdy=%b resp=%b mreq=%b exp 1 0 0", c, req_ready, resp_valid, mem_req_valid);
         end
         step();
      end
   endtask

   task automatic test_back_to_back;
      run_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 1, "b2b_sw");
      run_op(1'b0, 3'b010, 32'h10, 32'h0, 0, 1, "b2b_lw");
      run_op(1'b0, 3'b101, 32'h12, 32'h0, 0, 1, "b2b_lhu");
   endtask

   task automatic test_random;
      for (int n = 0; n < 60; n++)
         run_op(1'($urandom), 3'($urandom), 32'($urandom_range(0, 1020)), $urandom,
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), "rand");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);
      test_reset();
      test_load_ext();
      test_store_stall();
      test_errors();
      test_timeout();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
